// File: rtl/pc_unit_ras.sv
// Program-counter unit with branch/jump resolution, IF/ID kill and a circular return-address stack.
// Latency: decode is combinational; a redirect appears on pc one clock edge after the decode cycle.
// Backpressure: stall freezes pc and all RAS state and suppresses kill, while pc_src keeps tracking decode.
module pc_unit_ras #(
  parameter int                DATA_W      = 32,
  parameter int                INSTR_BYTES = 4,
  parameter int                IMM_SHIFT   = 2,
  parameter int                RAS_DEPTH   = 8,
  parameter logic [DATA_W-1:0] RESET_PC    = '0,
  parameter logic [5:0]        OP_BZ       = 6'b001010,
  parameter logic [5:0]        OP_BGZ      = 6'b001011,
  parameter logic [5:0]        OP_BLZ      = 6'b001100,
  parameter logic [5:0]        OP_JR       = 6'b001101,
  parameter logic [5:0]        OP_J        = 6'b001110,
  parameter logic [5:0]        OP_CLL      = 6'b001111,
  parameter logic [5:0]        OP_RET      = 6'b010000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic [5:0]                 opcode,
  input  logic                       zero,
  input  logic                       positive,
  input  logic                       negative,
  input  logic [DATA_W-1:0]          id_pc,
  input  logic [DATA_W-1:0]          imm_ext,
  input  logic [DATA_W-1:0]          reg_addr,
  output logic [DATA_W-1:0]          pc,
  output logic [1:0]                 pc_src,
  output logic                       kill,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_overflow,
  output logic                       ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [DATA_W-1:0] PC_STEP  = DATA_W'(INSTR_BYTES);

  localparam logic [1:0] SRC_SEQ = 2'b00;
  localparam logic [1:0] SRC_REG = 2'b01;
  localparam logic [1:0] SRC_REL = 2'b10;
  localparam logic [1:0] SRC_RAS = 2'b11;

  logic [DATA_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  top_q, top_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [DATA_W-1:0] ras_mem_q [RAS_DEPTH];

  logic [1:0]        src;
  logic              is_call;
  logic              is_ret;
  logic              ras_empty;
  logic              push;
  logic              pop;
  logic [PTR_W-1:0]  top_m1;
  logic [DATA_W-1:0] seq_tgt;
  logic [DATA_W-1:0] rel_tgt;
  logic [DATA_W-1:0] ras_tgt;
  logic [DATA_W-1:0] ret_addr;
  logic [DATA_W-1:0] target;

  assign ras_empty = (cnt_q == '0);
  assign top_m1    = top_q - PTR_W'(1);
  assign seq_tgt   = pc_q + PC_STEP;
  assign rel_tgt   = id_pc + (imm_ext <<< IMM_SHIFT);
  assign ras_tgt   = ras_mem_q[top_m1];
  assign ret_addr  = id_pc + PC_STEP;

  // Opcode decode: pick the PC source and flag call/return instructions.
  always_comb begin
    src     = SRC_SEQ;
    is_call = 1'b0;
    is_ret  = 1'b0;
    case (opcode)
      OP_BZ:  src = zero     ? SRC_REL : SRC_SEQ;
      OP_BGZ: src = positive ? SRC_REL : SRC_SEQ;
      OP_BLZ: src = negative ? SRC_REL : SRC_SEQ;
      OP_JR:  src = SRC_REG;
      OP_J:   src = SRC_REL;
      OP_CLL: begin
        src     = SRC_REL;
        is_call = 1'b1;
      end
      OP_RET: begin
        // An empty stack falls back to the register target.
        src    = ras_empty ? SRC_REG : SRC_RAS;
        is_ret = 1'b1;
      end
      default: src = SRC_SEQ;
    endcase
  end

  // Target mux and next-state for PC, stack pointer, occupancy and flags.
  always_comb begin
    case (src)
      SRC_REG: target = reg_addr;
      SRC_REL: target = rel_tgt;
      SRC_RAS: target = ras_tgt;
      default: target = seq_tgt;
    endcase

    push = is_call & ~stall;
    pop  = is_ret & ~ras_empty & ~stall;

    pc_d  = stall ? pc_q : target;
    top_d = top_q;
    cnt_d = cnt_q;
    if (push) begin
      top_d = top_q + PTR_W'(1);
      cnt_d = (cnt_q == CNT_FULL) ? CNT_FULL : cnt_q + CNT_W'(1);
    end else if (pop) begin
      top_d = top_m1;
      cnt_d = cnt_q - CNT_W'(1);
    end

    // Overflow is sticky; underflow only reflects the most recent unstalled edge.
    ovf_d = ovf_q | (push & (cnt_q == CNT_FULL));
    unf_d = is_ret & ras_empty & ~stall;
  end

  // Control state: PC, stack pointer, occupancy and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack storage; contents are meaningless while the count says empty, so no reset.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      ras_mem_q[top_q] <= ret_addr;
    end
  end

  assign pc            = pc_q;
  assign pc_src        = src;
  assign kill          = (src != SRC_SEQ) & ~stall;
  assign ras_count     = cnt_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Self-checking bench for pc_unit_ras: directed table, hand-written corner sequences,
// randomized traffic against a queue-based reference model, and a small-parameter instance.
module tb_pc_unit_ras;

  localparam logic [5:0] BZ  = 6'b001010;
  localparam logic [5:0] BGZ = 6'b001011;
  localparam logic [5:0] BLZ = 6'b001100;
  localparam logic [5:0] JR  = 6'b001101;
  localparam logic [5:0] J   = 6'b001110;
  localparam logic [5:0] CLL = 6'b001111;
  localparam logic [5:0] RET = 6'b010000;
  localparam logic [5:0] NOP = 6'b000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (default parameters)
  logic        reset, stall, zero, positive, negative;
  logic [5:0]  opcode;
  logic [31:0] id_pc, imm_ext, reg_addr, pc;
  logic [1:0]  pc_src;
  logic        kill, ras_overflow, ras_underflow;
  logic [3:0]  ras_count;

  pc_unit_ras #(.DATA_W(32), .INSTR_BYTES(4), .IMM_SHIFT(2), .RAS_DEPTH(8), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .opcode(opcode), .zero(zero), .positive(positive),
    .negative(negative), .id_pc(id_pc), .imm_ext(imm_ext), .reg_addr(reg_addr), .pc(pc),
    .pc_src(pc_src), .kill(kill), .ras_count(ras_count), .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow));

  // Small instance
  logic        b_reset, b_stall, b_zero, b_positive, b_negative;
  logic [5:0]  b_opcode;
  logic [15:0] b_id_pc, b_imm_ext, b_reg_addr, b_pc;
  logic [1:0]  b_pc_src;
  logic        b_kill, b_ras_overflow, b_ras_underflow;
  logic [2:0]  b_ras_count;

  pc_unit_ras #(.DATA_W(16), .INSTR_BYTES(2), .IMM_SHIFT(2), .RAS_DEPTH(4), .RESET_PC(16'h0100)) dut_b (
    .clk(clk), .reset(b_reset), .stall(b_stall), .opcode(b_opcode), .zero(b_zero),
    .positive(b_positive), .negative(b_negative), .id_pc(b_id_pc), .imm_ext(b_imm_ext),
    .reg_addr(b_reg_addr), .pc(b_pc), .pc_src(b_pc_src), .kill(b_kill),
    .ras_count(b_ras_count), .ras_overflow(b_ras_overflow), .ras_underflow(b_ras_underflow));

  int n_tot  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Reference model: a bounded list of return addresses, oldest at the front.
  logic [31:0] m_pc;
  logic [31:0] m_stk[$];
  bit          m_ovf, m_unf;

  function automatic logic [1:0] m_src(input logic [5:0] op, input logic z, p, n);
    case (op)
      BZ:      return z ? 2'd2 : 2'd0;
      BGZ:     return p ? 2'd2 : 2'd0;
      BLZ:     return n ? 2'd2 : 2'd0;
      JR:      return 2'd1;
      J, CLL:  return 2'd2;
      RET:     return (m_stk.size() > 0) ? 2'd3 : 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  // One decode cycle: check combinational outputs, advance model, check registered outputs.
  task automatic cyc(input logic st, input logic [5:0] op, input logic z, p, n,
                     input logic [31:0] ip, im, ra, output logic [1:0] o_src, output logic o_kill);
    logic [1:0]  es;
    logic [31:0] tgt;
    @(negedge clk);
    reset = 1'b0; stall = st; opcode = op; zero = z; positive = p; negative = n;
    id_pc = ip; imm_ext = im; reg_addr = ra;
    #1;
    o_src = pc_src; o_kill = kill;
    es = m_src(op, z, p, n);
    chk("pc_src", {30'd0, pc_src}, {30'd0, es});
    chk("kill", {31'd0, kill}, {31'd0, (es != 2'd0) && !st});
    if (!st) begin
      case (es)
        2'd1:    tgt = ra;
        2'd2:    tgt = ip + (im * 4);
        2'd3:    tgt = m_stk[$];
        default: tgt = m_pc + 4;
      endcase
      m_unf = (op == RET) && (m_stk.size() == 0);
      if (op == CLL) begin
        if (m_stk.size() == 8) begin
          void'(m_stk.pop_front());
          m_ovf = 1'b1;
        end
        m_stk.push_back(ip + 4);
      end else if (op == RET && m_stk.size() > 0) begin
        void'(m_stk.pop_back());
      end
      m_pc = tgt;
    end else begin
      m_unf = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("pc", pc, m_pc);
    chk("ras_count", {28'd0, ras_count}, m_stk.size());
    chk("ras_overflow", {31'd0, ras_overflow}, {31'd0, m_ovf});
    chk("ras_underflow", {31'd0, ras_underflow}, {31'd0, m_unf});
  endtask

  task automatic rst1(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      reset = 1'b1; stall = 1'b0; opcode = J;
      @(posedge clk);
      #1;
      chk("rst_pc", pc, 32'h0);
      chk("rst_count", {28'd0, ras_count}, 32'd0);
      chk("rst_flags", {30'd0, ras_overflow, ras_underflow}, 32'd0);
    end
    m_pc = 32'h0; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic bcyc(input logic [5:0] op, input logic [15:0] ip, ra);
    @(negedge clk);
    b_reset = 1'b0; b_stall = 1'b0; b_opcode = op; b_id_pc = ip; b_reg_addr = ra; b_imm_ext = 16'h0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        st;
    logic [5:0]  op;
    logic        z, p, n;
    logic [31:0] ip, im, ra;
    logic [1:0]  src;
    logic        kl;
    logic        seq;
    logic [31:0] npc;
    int          cnt;
  } vec_t;

  vec_t        tbl[12];
  logic [1:0]  s;
  logic        k;
  logic [31:0] prev, p0;
  int          c0;

  initial begin
    reset = 1'b1; stall = 1'b0; opcode = J; zero = 0; positive = 0; negative = 0;
    id_pc = 0; imm_ext = 0; reg_addr = 0;
    b_reset = 1'b1; b_stall = 1'b0; b_opcode = NOP; b_zero = 0; b_positive = 0; b_negative = 0;
    b_id_pc = 0; b_imm_ext = 0; b_reg_addr = 0;

    tbl[0]  = '{0, BZ,  1, 0, 0, 32'h40,  -32'sd2, 32'h0,    2'd2, 1, 0, 32'h38,   0};
    tbl[1]  = '{0, BZ,  0, 1, 1, 32'h40,  -32'sd2, 32'h0,    2'd0, 0, 1, 32'h0,    0};
    tbl[2]  = '{0, BGZ, 0, 1, 0, 32'h40,  -32'sd2, 32'h0,    2'd2, 1, 0, 32'h38,   0};
    tbl[3]  = '{0, BGZ, 1, 0, 1, 32'h40,  -32'sd2, 32'h0,    2'd0, 0, 1, 32'h0,    0};
    tbl[4]  = '{0, BLZ, 0, 0, 1, 32'h40,  -32'sd2, 32'h0,    2'd2, 1, 0, 32'h38,   0};
    tbl[5]  = '{0, BLZ, 1, 1, 0, 32'h40,  -32'sd2, 32'h0,    2'd0, 0, 1, 32'h0,    0};
    tbl[6]  = '{0, JR,  0, 0, 0, 32'h40,  32'h0,   32'h1234, 2'd1, 1, 0, 32'h1234, 0};
    tbl[7]  = '{0, CLL, 0, 0, 0, 32'h100, 32'h8,   32'h0,    2'd2, 1, 0, 32'h120,  1};
    tbl[8]  = '{0, RET, 0, 0, 0, 32'h0,   32'h0,   32'h777,  2'd3, 1, 0, 32'h104,  0};
    tbl[9]  = '{0, RET, 0, 0, 0, 32'h0,   32'h0,   32'h500,  2'd1, 1, 0, 32'h500,  0};
    tbl[10] = '{0, NOP, 1, 1, 1, 32'h40,  32'h8,   32'h99,   2'd0, 0, 1, 32'h0,    0};
    tbl[11] = '{1, J,   0, 0, 0, 32'h40,  32'h8,   32'h0,    2'd2, 0, 1, 32'h0,    0};

    // Reset with a jump on the decode inputs: kill is combinational but pc must stay put.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk("rst_kill_comb", {31'd0, kill}, 32'd1);
      @(posedge clk);
      #1;
      chk("rst_pc", pc, 32'h0);
      chk("rst_count", {28'd0, ras_count}, 32'd0);
      chk("rst_flags", {30'd0, ras_overflow, ras_underflow}, 32'd0);
    end
    m_pc = 32'h0; m_stk.delete(); m_ovf = 0; m_unf = 0;
    for (int i = 1; i <= 3; i++) begin
      cyc(0, NOP, 0, 0, 0, 0, 0, 0, s, k);
      chk("idle_pc", pc, 32'(4 * i));
    end

    // Directed table
    for (int i = 0; i < 12; i++) begin
      prev = m_pc;
      cyc(tbl[i].st, tbl[i].op, tbl[i].z, tbl[i].p, tbl[i].n, tbl[i].ip, tbl[i].im, tbl[i].ra, s, k);
      chk($sformatf("tbl%0d_src", i), {30'd0, s}, {30'd0, tbl[i].src});
      chk($sformatf("tbl%0d_kill", i), {31'd0, k}, {31'd0, tbl[i].kl});
      chk($sformatf("tbl%0d_pc", i), pc,
          tbl[i].seq ? (tbl[i].st ? prev : prev + 32'd4) : tbl[i].npc);
      chk($sformatf("tbl%0d_cnt", i), {28'd0, ras_count}, tbl[i].cnt);
      if (i == 9) chk("tbl_underflow", {31'd0, ras_underflow}, 32'd1);
    end

    // Nested calls return LIFO
    cyc(0, CLL, 0, 0, 0, 32'h200, 32'h10, 0, s, k);
    cyc(0, CLL, 0, 0, 0, 32'h300, 32'h10, 0, s, k);
    cyc(0, CLL, 0, 0, 0, 32'h400, 32'h10, 0, s, k);
    cyc(0, RET, 0, 0, 0, 0, 0, 0, s, k); chk("nest_ret1", pc, 32'h404);
    cyc(0, RET, 0, 0, 0, 0, 0, 0, s, k); chk("nest_ret2", pc, 32'h304);
    cyc(0, RET, 0, 0, 0, 0, 0, 0, s, k); chk("nest_ret3", pc, 32'h204);

    // Overflow: nine calls into eight entries, oldest is lost
    for (int kk = 1; kk <= 9; kk++) cyc(0, CLL, 0, 0, 0, 32'(16 * kk), 32'h0, 0, s, k);
    chk("ovf_count", {28'd0, ras_count}, 32'd8);
    chk("ovf_flag", {31'd0, ras_overflow}, 32'd1);
    for (int j = 1; j <= 8; j++) begin
      cyc(0, RET, 0, 0, 0, 0, 0, 32'h500, s, k);
      chk($sformatf("ovf_ret%0d", j), pc, 32'(16 * (10 - j) + 4));
    end
    chk("ovf_sticky", {31'd0, ras_overflow}, 32'd1);
    cyc(0, RET, 0, 0, 0, 0, 0, 32'h500, s, k);
    chk("unf_pc", pc, 32'h500);
    chk("unf_pulse", {31'd0, ras_underflow}, 32'd1);
    cyc(0, NOP, 0, 0, 0, 0, 0, 0, s, k);
    chk("unf_clear", {31'd0, ras_underflow}, 32'd0);

    // Stalled call: hold for three cycles, then exactly one push and redirect
    p0 = m_pc; c0 = m_stk.size();
    for (int i = 0; i < 3; i++) begin
      cyc(1, CLL, 0, 0, 0, 32'h300, 32'h4, 0, s, k);
      chk("stall_pc", pc, p0);
      chk("stall_src", {30'd0, s}, 32'd2);
      chk("stall_kill", {31'd0, k}, 32'd0);
      chk("stall_cnt", {28'd0, ras_count}, c0);
    end
    cyc(0, CLL, 0, 0, 0, 32'h300, 32'h4, 0, s, k);
    chk("unstall_pc", pc, 32'h310);
    chk("unstall_cnt", {28'd0, ras_count}, c0 + 1);

    // Stalled RET on empty stack must not pulse underflow; reset during stall clears RAS
    cyc(0, CLL, 0, 0, 0, 32'h600, 32'h0, 0, s, k);
    @(negedge clk);
    reset = 1'b1; stall = 1'b1; opcode = CLL;
    @(posedge clk);
    #1;
    chk("midrst_cnt", {28'd0, ras_count}, 32'd0);
    chk("midrst_pc", pc, 32'h0);
    m_pc = 32'h0; m_stk.delete(); m_ovf = 0; m_unf = 0;
    cyc(1, RET, 0, 0, 0, 0, 0, 32'h44, s, k);
    chk("stall_ret_unf", {31'd0, ras_underflow}, 32'd0);

    // Address wrap
    cyc(0, JR, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, s, k);
    cyc(0, NOP, 0, 0, 0, 0, 0, 0, s, k);
    chk("wrap_pc", pc, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [5:0]  op;
      logic [31:0] im;
      int          r;
      if ($urandom_range(0, 60) == 0) begin
        rst1(1);
      end else begin
        r = $urandom_range(0, 9);
        case (r)
          0: op = BZ;  1: op = BGZ; 2: op = BLZ; 3: op = JR;
          4: op = J;   5, 9: op = CLL; 6, 7: op = RET;
          default: op = 6'($urandom);
        endcase
        im = 32'($urandom_range(0, 63)) - 32'd32;
        cyc($urandom_range(0, 4) == 0, op, 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom, im, $urandom, s, k);
      end
    end

    // Small-parameter instance
    @(negedge clk);
    b_reset = 1'b1;
    @(posedge clk);
    #1;
    chk("b_rst_pc", {16'd0, b_pc}, 32'h100);
    chk("b_rst_cnt", {29'd0, b_ras_count}, 32'd0);
    bcyc(NOP, 16'h0, 16'h0);
    chk("b_seq_pc", {16'd0, b_pc}, 32'h102);
    for (int kk = 1; kk <= 5; kk++) begin
      bcyc(CLL, 16'(16 * kk), 16'h0);
      chk("b_call_pc", {16'd0, b_pc}, 32'(16 * kk));
      chk("b_call_cnt", {29'd0, b_ras_count}, (kk > 4) ? 32'd4 : 32'(kk));
      chk("b_call_ovf", {31'd0, b_ras_overflow}, (kk == 5) ? 32'd1 : 32'd0);
    end
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      b_opcode = RET;
      #1;
      chk("b_ret_src", {30'd0, b_pc_src}, 32'd3);
      @(posedge clk);
      #1;
      chk("b_ret_pc", {16'd0, b_pc}, 32'(16 * (6 - j) + 2));
    end
    bcyc(RET, 16'h0, 16'h0077);
    chk("b_unf_pc", {16'd0, b_pc}, 32'h77);
    chk("b_unf", {31'd0, b_ras_underflow}, 32'd1);
    bcyc(JR, 16'h0, 16'hFFFE);
    bcyc(NOP, 16'h0, 16'h0);
    chk("b_wrap_pc", {16'd0, b_pc}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
